ibex_rf_wb_arbiter: RTL
=======================

# ibex_rf_wb_arbiter

Write-back arbiter for the single register-file write port. It shares the port between the EX requester (ALU, multdiv and CSR results) and the LSU requester (load data). Losing EX writes are held in a small in-order buffer, and a starvation counter bounds how long EX can wait. Read-address hazard flags let the decoder/controller stall on pending buffered writes. The block sits between the EX/LSU result buses and the register file in the ID stage.

## Interface
- DEPTH, 2: EX holding-buffer entries; power of two, ≥2.
- MAX_WAIT, 4: consecutive lost cycles after which EX is granted; ≥1.

- clk_i  in  1  clock.
- rst_i  in  1  reset: one clock; reset is synchronous and active-high.
- ex_we_i  in  1  EX write request.
- ex_waddr_i  in  5  EX destination register.
- ex_wdata_i  in  32  EX write data.
- ex_ready_o  out  1  EX request accepted this cycle when high with ex_we_i.
- lsu_we_i  in  1  LSU write request.
- lsu_waddr_i  in  5  LSU destination register.
- lsu_wdata_i  in  32  LSU write data.
- lsu_ready_o  out  1  LSU request accepted (written) this cycle when high with lsu_we_i.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  32  register-file write data.
- raddr_a_i, raddr_b_i  in  5 each  decoder read addresses.
- hazard_a_o, hazard_b_o  out  1 each  read address matches a valid buffered entry.
- wb_pending_o  out  $clog2(DEPTH)+1  buffer occupancy.

## Operation
- State: circular buffer (DEPTH entries of {waddr, wdata}, rd/wr pointers, count 0..DEPTH) and starve counter `starve` (0..MAX_WAIT, saturating).
- EX-side candidate: buffer head if count>0, otherwise the direct EX request (ex_we_i & ex_waddr_i≠0). A direct EX request never bypasses non-empty buffer contents, so EX writes retire in acceptance order.
- ex_ready_o = (count<DEPTH). Acceptance is independent of ex_we_i.
- lsu_ready_o = !(starve==MAX_WAIT && EX-side candidate exists).
- Grant per cycle, at most one write:
  1. If starve==MAX_WAIT and an EX-side candidate exists: EX-side wins. LSU is back-pressured.
  2. Otherwise, if lsu_we_i & lsu_waddr_i≠0: LSU wins.
  3. Otherwise, if an EX-side candidate exists: EX-side wins.
  4. Otherwise: rf_we_o=0.
- x0 writes (waddr==0) from either side are accepted per the ready rules but dropped. They are never pushed and never drive rf_we_o.
- Push: an accepted direct EX request (nonzero addr) that was not granted is written at wr pointer. A buffer-head grant pops. Push and pop may occur in the same cycle; count is then unchanged. Pointers wrap modulo DEPTH.
- starve:
  - +1 (saturating) when an EX-side candidate exists and LSU wins.
  - Cleared when EX-side is granted or no EX-side candidate exists.
- hazard_x_o = OR over valid entries of (entry.waddr==raddr_x_i), with raddr_x_i≠0. A same-cycle direct EX request is not included.
- Reset (rst_i high): count, pointers and starve cleared. While rst_i is high, all outputs are forced low (ex_ready_o=0, lsu_ready_o=0, rf_we_o=0, hazards 0) and no request is accepted. Buffer contents are discarded when reset is asserted mid-operation.

## Timing
- Direct EX or LSU grant: combinational, 0-cycle latency; register file captures at the same clk_i edge.
- Buffered EX write: earliest retire is the cycle after acceptance.
- Throughput: 1 register write per cycle. The buffer drains at 1 entry/cycle when LSU is idle.
- Maximum LSU stall: 1 cycle per EX-side forced grant. Maximum EX wait while LSU streams: MAX_WAIT cycles.
- ex_ready_o, lsu_ready_o and hazards depend only on registered state plus same-cycle request inputs; there is no ready-to-ready combinational loop.
- After reset deassertion: ex_ready_o=1, lsu_ready_o=1, wb_pending_o=0.

## Test plan
- EX-only: EX writes x5=0x1234_5678 with buffer empty and LSU idle → same cycle rf_we_o=1, waddr=5, wdata=0x12345678; wb_pending_o stays 0.
- Collision: EX x3=0xA and LSU x4=0xB in the same cycle → LSU written in cycle 0, wb_pending_o=1, hazard_a_o=1 when raddr_a_i=3; x3=0xA written in cycle 1, then wb_pending_o=0.
- Full buffer: LSU streams continuously; EX issues 3 requests (DEPTH=2) → first 2 accepted, ex_ready_o=0 on the 3rd; ex_ready_o returns to 1 the cycle after the first pop.
- Starvation: LSU requests every cycle with one EX entry buffered, MAX_WAIT=4 → LSU wins 4 cycles; in cycle 5 lsu_ready_o=0 and the EX entry is written; starve=0 afterward.
- x0: EX x0=0xFFFF_FFFF and LSU x0 in the same cycle → both ready high, rf_we_o=0, wb_pending_o=0.
- Mid-op reset: 2 entries buffered, rst_i pulsed 1 cycle → outputs 0 during reset; afterward wb_pending_o=0, no stale write issued, ex_ready_o=1.

Source files
------------

// File: rtl/ibex_rf_wb_arbiter.sv
// Write-back arbiter sharing the single register-file write port between EX and LSU.
// Losing EX writes queue in an in-order buffer; a starvation counter bounds EX wait.
module ibex_rf_wb_arbiter #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ex_we_i,
    input  logic [4:0]                 ex_waddr_i,
    input  logic [31:0]                ex_wdata_i,
    output logic                       ex_ready_o,
    input  logic                       lsu_we_i,
    input  logic [4:0]                 lsu_waddr_i,
    input  logic [31:0]                lsu_wdata_i,
    output logic                       lsu_ready_o,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_waddr_o,
    output logic [31:0]                rf_wdata_o,
    input  logic [4:0]                 raddr_a_i,
    input  logic [4:0]                 raddr_b_i,
    output logic                       hazard_a_o,
    output logic                       hazard_b_o,
    output logic [$clog2(DEPTH):0]     wb_pending_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SW    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [4:0]       buf_waddr_q [DEPTH];
    logic [31:0]      buf_wdata_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic buf_nonempty, ex_direct, ex_cand, lsu_valid, force_ex;
    logic grant_ex, grant_lsu, push, pop;

    always_comb begin
        buf_nonempty = (count_q != '0);
        ex_ready_o   = !rst_i && (count_q < CNT_W'(DEPTH));
        // Accepted direct EX request with a real destination.
        ex_direct    = ex_we_i && (ex_waddr_i != 5'd0) && ex_ready_o;
        ex_cand      = !rst_i && (buf_nonempty || ex_direct);
        lsu_valid    = !rst_i && lsu_we_i && (lsu_waddr_i != 5'd0);
        force_ex     = ex_cand && (starve_q == SW'(MAX_WAIT));
        lsu_ready_o  = !rst_i && !force_ex;
        grant_ex     = ex_cand && (force_ex || !lsu_valid);
        grant_lsu    = lsu_valid && !force_ex;
        pop          = grant_ex && buf_nonempty;
        // A direct request is pushed unless it went straight to the register file.
        push         = ex_direct && !(grant_ex && !buf_nonempty);

        rf_we_o    = grant_ex || grant_lsu;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (grant_lsu) begin
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (pop) begin
            rf_waddr_o = buf_waddr_q[rd_ptr_q];
            rf_wdata_o = buf_wdata_q[rd_ptr_q];
        end else if (grant_ex) begin
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end

        hazard_a_o = 1'b0;
        hazard_b_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Entry i is valid when its distance from the head is below the occupancy.
            if (!rst_i && ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q)) begin
                if (raddr_a_i != 5'd0 && buf_waddr_q[i] == raddr_a_i) hazard_a_o = 1'b1;
                if (raddr_b_i != 5'd0 && buf_waddr_q[i] == raddr_b_i) hazard_b_o = 1'b1;
            end
        end

        wb_pending_o = rst_i ? '0 : count_q;

        rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        wr_ptr_d = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = CNT_W'(count_q + 1'b1);
        if (pop && !push) count_d = CNT_W'(count_q - 1'b1);

        starve_d = '0;
        if (ex_cand && grant_lsu)
            starve_d = (starve_q == SW'(MAX_WAIT)) ? starve_q : SW'(starve_q + 1'b1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_waddr_q[wr_ptr_q] <= ex_waddr_i;
            buf_wdata_q[wr_ptr_q] <= ex_wdata_i;
        end
    end

endmodule
